// File: rtl/mul_pipe_ctrl.sv
// Two-stage sequencing controller around the Wallace-tree 32x32 multiplier.
// Optional perf counters are enabled by defining MUL_PIPE_PERF_CNT_EN.
module mul_pipe_ctrl #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [DATA_W-1:0]     in_src1,
   input  logic [DATA_W-1:0]     in_src2,
   input  logic [TAG_W-1:0]      in_tag,
   input  logic                  flush,
   output logic [DATA_W:0]       tree_x,
   output logic [DATA_W:0]       tree_y,
   input  logic [2*DATA_W+1:0]   tree_sum,
   input  logic [2*DATA_W+1:0]   tree_carry,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_result,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  busy,
   output logic [31:0]           perf_issue,
   output logic [31:0]           perf_stall
);

   localparam int PW = 2 * DATA_W;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULH  = 2'b01,
      OP_MULHU = 2'b10,
      OP_RSVD  = 2'b11
   } op_t;

   logic              v1;
   logic              v2;
   logic [PW-1:0]     sum1;
   logic [PW-1:0]     carry1;
   logic [1:0]        op1;
   logic [TAG_W-1:0]  tag1;
   logic              adv2;
   logic              accept;
   logic              sext;
   logic [PW-1:0]     prod;
   logic [DATA_W-1:0] sel;
   logic              unused_tree_hi;

   // Only the low 2*DATA_W product bits can reach either result word.
   assign unused_tree_hi = ^{tree_sum[PW+1:PW], tree_carry[PW+1:PW]};

   assign adv2     = !v2 || out_ready;
   assign in_ready = (!v1 || adv2) && !flush;
   assign accept   = in_valid && in_ready;
   assign busy     = v1 || v2;
   assign out_valid = v2;

   always_comb begin
      sext   = (op_t'(in_op) == OP_MULH);
      tree_x = {sext & in_src1[DATA_W-1], in_src1};
      tree_y = {sext & in_src2[DATA_W-1], in_src2};
   end

   always_comb begin
      prod = sum1 + carry1;
      sel  = prod[DATA_W-1:0];
      case (op_t'(op1))
         OP_MULH, OP_MULHU: sel = prod[PW-1:DATA_W];
         OP_MUL, OP_RSVD:   sel = prod[DATA_W-1:0];
         default:           sel = prod[DATA_W-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1     <= 1'b0;
         sum1   <= '0;
         carry1 <= '0;
         op1    <= '0;
         tag1   <= '0;
      end else if (flush) begin
         v1 <= 1'b0;
      end else if (accept) begin
         v1     <= 1'b1;
         sum1   <= tree_sum[PW-1:0];
         carry1 <= tree_carry[PW-1:0];
         op1    <= in_op;
         tag1   <= in_tag;
      end else if (adv2) begin
         v1 <= 1'b0;
      end
   end

   // Result registers only load on a real handoff so a stalled word stays put.
   always_ff @(posedge clk) begin
      if (reset) begin
         v2         <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else if (flush) begin
         v2 <= 1'b0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            out_result <= sel;
            out_tag    <= tag1;
         end
      end
   end

`ifdef MUL_PIPE_PERF_CNT_EN
   logic [31:0] issue_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept)
            issue_cnt <= issue_cnt + 32'd1;
         if (v2 && !out_ready)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_issue = issue_cnt;
   assign perf_stall = stall_cnt;
`else
   assign perf_issue = '0;
   assign perf_stall = '0;
`endif

endmodule

// File: doc/mul_pipe_ctrl.md
Name: mul_pipe_ctrl

Overview:
- Sequencing controller for the 32x32 multiplier built from the team's Wallace-tree compressor array.
- Accepts multiply ops from the EX stage via valid/ready and drives sign- or zero-extended operands into the combinational partial-product/Wallace datapath.
- Registers the tree's redundant sum/carry, performs the final carry-propagate add, selects the hi/lo word and holds the result until writeback accepts it.
- 2-stage pipeline, throughput 1 op/cycle; supports flush on exception or branch mispredict.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 5, destination tag width (rd index)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  op request
- in_ready  out  1  controller can accept
- in_op  in  2  00=MUL.W (low word), 01=MULH.W (signed high), 10=MULH.WU (unsigned high), 11=reserved
- in_src1  in  DATA_W  multiplicand
- in_src2  in  DATA_W  multiplier
- in_tag  in  TAG_W  destination tag
- flush  in  1  kill all in-flight ops
- tree_x  out  DATA_W+1  extended src1 to tree
- tree_y  out  DATA_W+1  extended src2 to tree
- tree_sum  in  2*DATA_W+2  tree redundant sum, same cycle as tree_x/y
- tree_carry  in  2*DATA_W+2  tree redundant carry, same cycle
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_result  out  DATA_W  selected word
- out_tag  out  TAG_W  tag of result
- busy  out  1  any stage valid
- perf_issue  out  32  accepted-op counter (optional feature)
- perf_stall  out  32  output-stall counter (optional feature)

Behaviour:
- Extension is combinational from in_src1/in_src2/in_op:
  - op 01: sign-extend to DATA_W+1 bits.
  - op 00/10/11: zero-extend.
  - Tree outputs are sampled only on accept.
- Accept: in_valid & in_ready at a rising edge. Stage 1 captures v1=1, tree_sum, tree_carry, op, tag.
- Stage 2 on advance: v2<=v1, out_tag<=tag1, and out_result is computed from p = (sum1 + carry1) mod 2^(2*DATA_W+2):
  - op 00/11: p[31:0]
  - op 01/10: p[63:32]
  - Op 11 is reserved and behaves as 00.
- Handshake:
  - adv2 = !v2 | out_ready
  - in_ready = (!v1 | adv2) & !flush
  - Stage 1 moves to stage 2 only when adv2. If stage 1 holds and is not accepting, it keeps its value.
- Latency: out_valid asserts 2 cycles after the accept edge when out_ready is held at 1. Back-to-back accepts give one result per cycle.
- Output stability: while out_valid & !out_ready, out_result and out_tag are held constant.
- Output handoff with no new data: if out_valid & out_ready and stage 1 is empty, v2 clears next edge.
- Flush (priority over accept and advance):
  - At the edge with flush=1, v1 and v2 clear.
  - in_ready is 0 in that cycle, and in_valid is ignored.
  - A result presented with out_valid & out_ready in the flush cycle still counts as delivered.
- busy = v1 | v2.
- Reset: v1=v2=0, out_valid=0, out_result=0, out_tag=0, stage-1 data=0, perf counters=0. in_ready is 1 the first cycle after reset.
- Reset mid-operation discards all in-flight ops; no result is emitted.

Optional Feature:
- Macro: MUL_PIPE_PERF_CNT_EN.
- Defined:
  - perf_issue increments on each accept.
  - perf_stall increments each cycle out_valid & !out_ready.
  - Both wrap at 2^32, clear on reset, and are unaffected by flush.
- Undefined: counters are not instantiated, and perf_issue and perf_stall are tied to 0.

Test Plan:
- Bench tree model: tree_sum = extended product, tree_carry = 0.
  - src1=0xFFFFFFFF, src2=0x2, ops 00/01/10 in consecutive cycles with out_ready=1 -> out_result 0xFFFFFFFE, 0xFFFFFFFF, 0x00000001 on 3 consecutive cycles, first at accept+2, tags preserved.
- Tree model split (sum=P-0x12345, carry=0x12345): op 01, src1=0x80000000, src2=0x80000000 -> 0x40000000; op 00 -> 0x00000000.
- Backpressure: issue 3 ops, out_ready=0 for 5 cycles ->
  - out_valid steady, first result held;
  - in_ready drops after 2 ops are in flight;
  - on release, 3 results in order on consecutive cycles.
- Flush with both stages valid -> next cycle busy=0, out_valid=0; in_ready=0 during the flush cycle; a following op completes normally.
- Reset asserted while 2 ops are in flight -> no out_valid afterward, out_result=0, in_ready=1 the cycle after reset deasserts.
- With MUL_PIPE_PERF_CNT_EN: 4 accepts plus 3 stall cycles -> perf_issue=4, perf_stall=3; without the macro both read 0.
